// File: rtl/shift_left_iter.sv
// rtl/shift_left_iter.sv - multi-cycle iterative logical left shifter (SLL/SLLI)
module shift_left_iter #(
  parameter int XLEN = 32,
  parameter int SHW  = 5,
  parameter int STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [SHW-1:0]  shamt_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] rd_left_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // STEP never exceeds XLEN/2, so it always fits in the shift-amount width.
  localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

  state_e            state_q;
  logic [XLEN-1:0]   acc_q;
  logic [SHW-1:0]    rem_q;
  logic              done_q;
  logic [XLEN-1:0]   rd_q;

  logic [SHW-1:0]    step_d;
  logic [XLEN-1:0]   acc_d;
  logic [SHW-1:0]    rem_d;

  // Per-cycle shift: at most STEP bits, never more than what remains.
  always_comb begin
    step_d = (rem_q < STEP_W) ? rem_q : STEP_W;
    acc_d  = acc_q << step_d;
    rem_d  = rem_q - step_d;
  end

  // Control FSM with registered done/result; flush outranks everything but reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      rd_q    <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (shamt_i == '0) begin
              // Zero shift needs no iteration; answer directly.
              rd_q   <= rs1_i;
              done_q <= 1'b1;
            end else begin
              acc_q   <= rs1_i;
              rem_q   <= shamt_i;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          if (rem_d == '0) begin
            rd_q    <= acc_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q == SHIFT);
  assign done_o    = done_q;
  assign rd_left_o = rd_q;

endmodule

// File: tb/tb_shift_left_iter.sv
// tb/tb_shift_left_iter.sv - self-checking bench for shift_left_iter (STEP=1 and STEP=4)
module tb_shift_left_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [31:0] rs1;
  logic [4:0]  sh;
  logic        busy1, done1, busy4, done4;
  logic [31:0] rd1, rd4;

  int errors = 0;
  int checks = 0;
  logic [31:0] prev_res;

  always #5 clk = ~clk;

  shift_left_iter #(.XLEN(32), .SHW(5), .STEP(1)) u_s1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .flush_i(flush),
    .rs1_i(rs1), .shamt_i(sh), .busy_o(busy1), .done_o(done1), .rd_left_o(rd1)
  );

  shift_left_iter #(.XLEN(32), .SHW(5), .STEP(4)) u_s4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .flush_i(flush),
    .rs1_i(rs1), .shamt_i(sh), .busy_o(busy4), .done_o(done4), .rd_left_o(rd4)
  );

  typedef struct {
    logic [31:0] a;
    logic [4:0]  s;
    int          pulse_at;
    logic [31:0] exp;
    int          lat1;
    int          lat4;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int model_lat(input int s, input int step);
    return (s + step - 1) / step + 1;
  endfunction

  // Start one operation in cycle 0 and observe both DUTs for 40 cycles.
  // lat of 0 means no done pulse is expected.
  task automatic run_op(input string nm, input logic [31:0] a, input logic [4:0] s,
                        input int pulse_at, input int flush_at,
                        input logic [31:0] e1, input logic [31:0] e4,
                        input int l1, input int l4);
    int d1 = 0, d4 = 0, f1 = 0, f4 = 0, b1 = 0, ovl = 0;
    @(negedge clk);
    start = 1'b1; rs1 = a; sh = s; flush = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done1) begin d1++; if (f1 == 0) f1 = c; end
      if (done4) begin d4++; if (f4 == 0) f4 = c; end
      if (busy1) b1++;
      if ((done1 && busy1) || (done4 && busy4)) ovl++;
      if (flush_at > 0 && c == flush_at + 1) begin
        chk($sformatf("%s busy1_after_flush", nm), {31'd0, busy1}, 32'd0);
        chk($sformatf("%s busy4_after_flush", nm), {31'd0, busy4}, 32'd0);
      end
      start = (c == pulse_at);
      rs1   = ~a;
      sh    = (c == pulse_at) ? 5'd1 : ~s;
      flush = (c == flush_at);
    end
    start = 1'b0; flush = 1'b0;
    chk($sformatf("%s done_cnt1", nm), d1, (l1 != 0) ? 32'd1 : 32'd0);
    chk($sformatf("%s done_cnt4", nm), d4, (l4 != 0) ? 32'd1 : 32'd0);
    chk($sformatf("%s lat1", nm), f1, l1);
    chk($sformatf("%s lat4", nm), f4, l4);
    chk($sformatf("%s rd1", nm), rd1, e1);
    chk($sformatf("%s rd4", nm), rd4, e4);
    chk($sformatf("%s busy_during_done", nm), ovl, 32'd0);
    if (flush_at == 0) chk($sformatf("%s busy1_cycles", nm), b1, l1 - 1);
  endtask

  vec_t tbl[8];

  initial begin
    tbl = '{
      '{32'h8000_0001,  5'd0, 0, 32'h8000_0001,  1, 1},
      '{32'h0000_000F,  5'd4, 0, 32'h0000_00F0,  5, 2},
      '{32'hFFFF_FFFF, 5'd31, 0, 32'h8000_0000, 32, 9},
      '{32'h0000_0001,  5'd3, 0, 32'h0000_0008,  4, 2},
      '{32'h1234_5678, 5'd16, 0, 32'h5678_0000, 17, 5},
      '{32'h0000_000F, 5'd12, 2, 32'h0000_F000, 13, 4},
      '{32'hDEAD_BEEF,  5'd1, 0, 32'hBD5B_7DDE,  2, 2},
      '{32'h0000_0003,  5'd8, 0, 32'h0000_0300,  9, 3}
    };

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; rs1 = '0; sh = '0;
    repeat (3) @(negedge clk);
    chk("reset busy1", {31'd0, busy1}, 32'd0);
    chk("reset done1", {31'd0, done1}, 32'd0);
    chk("reset rd1", rd1, 32'd0);
    chk("reset rd4", rd4, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].s, tbl[i].pulse_at, 0,
             tbl[i].exp, tbl[i].exp, tbl[i].lat1, tbl[i].lat4);
      prev_res = tbl[i].exp;
    end

    // Back-to-back: second start issued in the cycle the first done is visible.
    begin
      int c = 0;
      @(negedge clk);
      start = 1'b1; rs1 = 32'h1; sh = 5'd3;
      @(negedge clk);
      start = 1'b0;
      c = 1;
      while (!done1 && c < 40) begin
        @(negedge clk);
        c++;
      end
      chk("b2b first lat", c, 32'd4);
      chk("b2b first rd", rd1, 32'h8);
      start = 1'b1; rs1 = 32'h3; sh = 5'd1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b mid done", {31'd0, done1}, 32'd0);
      chk("b2b mid busy", {31'd0, busy1}, 32'd1);
      @(negedge clk);
      chk("b2b second done", {31'd0, done1}, 32'd1);
      chk("b2b second rd1", rd1, 32'h6);
      chk("b2b second rd4", rd4, 32'h6);
      prev_res = 32'h6;
      repeat (3) @(negedge clk);
    end

    // Flush at SHIFT cycle 2 of a shamt=5 op; for STEP=4 that is the final shift.
    run_op("flush", 32'hA5A5_A5A5, 5'd5, 0, 2, prev_res, prev_res, 0, 0);
    run_op("after_flush", 32'h0000_0101, 5'd5, 0, 0, 32'h0000_2020, 32'h0000_2020, 6, 3);
    prev_res = 32'h0000_2020;

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      int s;
      a = $urandom;
      s = $urandom_range(0, 31);
      run_op($sformatf("rand%0d", k), a, 5'(s), 0, 0, a << s, a << s,
             model_lat(s, 1), model_lat(s, 4));
      prev_res = a << s;
    end

    // Asynchronous reset between clock edges during SHIFT.
    begin
      int dn = 0;
      @(negedge clk);
      start = 1'b1; rs1 = 32'h0000_FFFF; sh = 5'd20;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async busy1", {31'd0, busy1}, 32'd0);
      chk("async busy4", {31'd0, busy4}, 32'd0);
      chk("async done1", {31'd0, done1}, 32'd0);
      chk("async rd1", rd1, 32'd0);
      chk("async rd4", rd4, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (done1 || done4) dn++;
      end
      chk("async no done", dn, 32'd0);
    end

    run_op("post_reset", 32'h0000_0007, 5'd29, 0, 0, 32'hE000_0000, 32'hE000_0000, 30, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_left_iter.md
Name: shift_left_iter

Overview:
- Multi-cycle iterative logical left shifter for the EX stage; the left-shift counterpart to the combinational arithmetic right shifter.
- Serves SLL/SLLI when area matters: the operand is captured on start, shifted STEP bits per cycle, and the result is returned with a done pulse.
- Sits beside the EX-stage shift units; the EX control holds the pipeline while busy_o is high.

Parameters:
- XLEN, 32, operand/result width.
- SHW, 5, shift-amount width; must equal log2(XLEN).
- STEP, 1, maximum bits shifted per cycle; power of two, 1..XLEN/2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  request; sampled only in IDLE.
- flush_i  in  1  abort the current operation (pipeline flush).
- rs1_i  in  XLEN  operand to shift.
- shamt_i  in  SHW  shift amount; unsigned, 0..XLEN-1.
- busy_o  out  1  high while in SHIFT.
- done_o  out  1  one-cycle pulse; rd_left_o is valid and newly updated.
- rd_left_o  out  XLEN  result = rs1_i << shamt_i with zero fill; holds its value until the next completion.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rst_ni=0, async): state=IDLE, acc=0, rem=0, busy_o=0, done_o=0, rd_left_o=0. Reset mid-operation discards the operation; no done_o follows.
- Internal registers: acc[XLEN], rem[SHW]. done_o and rd_left_o are registered outputs.
- IDLE, start_i=1, flush_i=0:
  - shamt_i=0: rd_left_o<=rs1_i, done_o<=1, stay IDLE.
  - Otherwise: acc<=rs1_i, rem<=shamt_i, go to SHIFT.
- SHIFT, each cycle:
  - s = min(STEP, rem); acc<=acc<<s; rem<=rem-s.
  - When rem-s==0: rd_left_o<=acc<<s, done_o<=1, go to IDLE.
- done_o is high for exactly one cycle per completed operation; it is 0 in every other cycle.
- Latency: done_o is visible ceil(shamt/STEP)+1 cycles after the cycle in which start_i was sampled.
  - shamt=0 -> 1 cycle.
  - shamt=31, STEP=1 -> 32 cycles.
- busy_o = (state==SHIFT). It is 0 in the cycle done_o is high.
- Back-to-back: start_i is accepted in the same cycle done_o is high, because the state is already IDLE.
- start_i in SHIFT is ignored; no queuing. Operands are not re-sampled during SHIFT.
- flush_i=1, priority below reset and above everything else:
  - State<=IDLE, rem<=0, done_o<=0.
  - rd_left_o keeps its previous value.
  - Simultaneous start_i is dropped.
  - Flush on the final shift cycle suppresses done_o and the rd_left_o update.
- Bits shifted past bit XLEN-1 are discarded; vacated LSBs are 0. No sign extension, no exceptions.
- shamt bits above SHW-1 do not exist. Callers pass instr[24:20] or rs2[4:0].

Test Plan:
- Reset, then start with rs1=0x8000_0001, shamt=0 -> next cycle done_o=1, rd_left_o=0x8000_0001, busy_o=0 throughout.
- STEP=1, rs1=0x0000_000F, shamt=4 -> busy_o high 4 cycles; done_o in cycle 5 after start; rd_left_o=0x0000_00F0.
- STEP=1, rs1=0xFFFF_FFFF, shamt=31 -> done_o after 32 cycles, rd_left_o=0x8000_0000. Repeat with STEP=4: done_o after 9 cycles, same result.
- Back-to-back: start (0x1, sh=3), then start (0x3, sh=1) on the done cycle -> rd_left_o=0x8, then 0x6 two cycles later. start_i pulsed mid-SHIFT -> ignored, result unchanged.
- Flush at SHIFT cycle 2 of a shamt=5 operation -> done_o never asserts, rd_left_o keeps its prior value, busy_o=0 next cycle. A following start completes correctly.
- Assert rst_ni=0 asynchronously mid-SHIFT (between clock edges) -> busy_o, done_o and rd_left_o go to 0 immediately; no done_o after release.
